countdown_timer: RTL and testbench

- Preset-and-decrement counterpart to the stopwatch. It loads a minutes:seconds value, counts down once per second-tick, and flags expiry.
- Sits beside the stopwatch in the timing subsystem and uses the same start/stop/clear control style and the same min/sec output format.
- Status encoding extends the stopwatch encoding with an EXPIRED code.

---
 rtl/countdown_timer.sv | 143 ++++++++++++++
 tb/tb_countdown_timer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Preset minutes:seconds countdown timer with start/stop/clear control and a one-cycle done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value on expiry instead of stopping.
module countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned MAX_MIN       = 99
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] load_min_i,
    input  logic [5:0] load_sec_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       clear_i,
    output logic [7:0] minutes_o,
    output logic [5:0] seconds_o,
    output logic [1:0] status_o,
    output logic       done_o
);
    localparam int unsigned   PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] ps_q, ps_d;
    logic          done_q, done_d;
    logic          count_zero;
    logic          tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [7:0]    shmin_q, shmin_d;
    logic [5:0]    shsec_q, shsec_d;
`endif

    function automatic logic [7:0] clamp_min(input logic [7:0] v);
        return (v > 8'(MAX_MIN)) ? 8'(MAX_MIN) : v;
    endfunction

    function automatic logic [5:0] clamp_sec(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    assign count_zero = (min_q == 8'd0) && (sec_q == 6'd0);
    assign tick       = (ps_q == PS_LAST);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        ps_d    = ps_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        shmin_d = shmin_q;
        shsec_d = shsec_q;
`endif
        if (clear_i) begin
            state_d = IDLE;
            min_d   = 8'd0;
            sec_d   = 6'd0;
            ps_d    = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shmin_d = 8'd0;
            shsec_d = 6'd0;
`endif
        end else if (load_i && (state_q != RUNNING)) begin
            state_d = IDLE;
            min_d   = clamp_min(load_min_i);
            sec_d   = clamp_sec(load_sec_i);
            ps_d    = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shmin_d = clamp_min(load_min_i);
            shsec_d = clamp_sec(load_sec_i);
`endif
        end else if (stop_i) begin
            // stop also masks a coincident start or tick
            if (state_q == RUNNING) state_d = PAUSED;
        end else if (state_q == RUNNING) begin
            if (tick) begin
                ps_d = '0;
                if (sec_q != 6'd0) begin
                    sec_d = sec_q - 6'd1;
                end else begin
                    sec_d = 6'd59;
                    min_d = min_q - 8'd1;
                end
                // only 0:01 can step to 0:00; m:00 always borrows to (m-1):59
                if ((min_q == 8'd0) && (sec_q == 6'd1)) begin
                    done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if ((shmin_q != 8'd0) || (shsec_q != 6'd0)) begin
                        min_d = shmin_q;
                        sec_d = shsec_q;
                    end else begin
                        state_d = EXPIRED;
                    end
`else
                    state_d = EXPIRED;
`endif
                end
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end else if (start_i && !count_zero && ((state_q == IDLE) || (state_q == PAUSED))) begin
            state_d = RUNNING;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            min_q   <= 8'd0;
            sec_q   <= 6'd0;
            ps_q    <= '0;
            done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shmin_q <= 8'd0;
            shsec_q <= 6'd0;
`endif
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            ps_q    <= ps_d;
            done_q  <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shmin_q <= shmin_d;
            shsec_q <= shsec_d;
`endif
        end
    end

    assign minutes_o = min_q;
    assign seconds_o = sec_q;
    assign status_o  = state_q;
    assign done_o    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: two instances (1 and 4 ticks per second) share stimulus
// and are checked against a total-seconds reference model.
module tb_countdown_timer;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] m;
        logic [5:0] s;
        logic [1:0] st;
        logic       d;
    } obs_t;

    typedef struct {
        int st;
        int tot;
        int ph;
        int shadow;
        bit done;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n, load, start, stop, clear;
    logic [7:0] load_min;
    logic [5:0] load_sec;
    logic [7:0] mA, mB;
    logic [5:0] sA, sB;
    logic [1:0] stA, stB;
    logic       dA, dB;

    obs_t qA[$];
    obs_t qB[$];
    mdl_t modA, modB;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    countdown_timer #(.TICKS_PER_SEC(1), .MAX_MIN(99)) u_t1 (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load), .load_min_i(load_min), .load_sec_i(load_sec),
        .start_i(start), .stop_i(stop), .clear_i(clear),
        .minutes_o(mA), .seconds_o(sA), .status_o(stA), .done_o(dA)
    );

    countdown_timer #(.TICKS_PER_SEC(4), .MAX_MIN(99)) u_t4 (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load), .load_min_i(load_min), .load_sec_i(load_sec),
        .start_i(start), .stop_i(stop), .clear_i(clear),
        .minutes_o(mB), .seconds_o(sB), .status_o(stB), .done_o(dB)
    );

    // Reference: count kept as total seconds, prescaler as a phase within the second.
    function automatic mdl_t step(mdl_t m, int T, bit rn, bit cl, bit ld, int lm, int ls, bit sa, bit so);
        mdl_t n = m;
        n.done = 1'b0;
        if (!rn) begin
            n.st = 0; n.tot = 0; n.ph = 0; n.shadow = 0;
        end else if (cl) begin
            n.st = 0; n.tot = 0; n.ph = 0; n.shadow = 0;
        end else if (ld && m.st != 1) begin
            n.tot    = ((lm > 99) ? 99 : lm) * 60 + ((ls > 59) ? 59 : ls);
            n.shadow = n.tot;
            n.st     = 0;
            n.ph     = 0;
        end else if (so) begin
            if (m.st == 1) n.st = 2;
        end else if (m.st == 1) begin
            if (m.ph == T - 1) begin
                n.ph  = 0;
                n.tot = m.tot - 1;
                if (n.tot == 0) begin
                    n.done = 1'b1;
                    if (AR && m.shadow != 0) n.tot = m.shadow;
                    else n.st = 3;
                end
            end else begin
                n.ph = m.ph + 1;
            end
        end else if (sa && (m.st == 0 || m.st == 2) && m.tot != 0) begin
            n.st = 1;
        end
        return n;
    endfunction

    function automatic obs_t exp_of(mdl_t m);
        obs_t o;
        o.m  = 8'(m.tot / 60);
        o.s  = 6'(m.tot % 60);
        o.st = 2'(m.st);
        o.d  = m.done;
        return o;
    endfunction

    function automatic obs_t obsA();
        obs_t o;
        o.m = mA; o.s = sA; o.st = stA; o.d = dA;
        return o;
    endfunction

    function automatic obs_t obsB();
        obs_t o;
        o.m = mB; o.s = sB; o.st = stB; o.d = dB;
        return o;
    endfunction

    task automatic chk(input string nm, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d:%0d status=%0d done=%0d, expected %0d:%0d status=%0d done=%0d",
                     nm, $time, act.m, act.s, act.st, act.d, exp.m, exp.s, exp.st, exp.d);
        end
    endtask

    task automatic tick_models();
        modA = step(modA, 1, rst_n, clear, load, int'(load_min), int'(load_sec), start, stop);
        modB = step(modB, 4, rst_n, clear, load, int'(load_min), int'(load_sec), start, stop);
        qA.push_back(exp_of(modA));
        qB.push_back(exp_of(modB));
    endtask

    // Monitor: every cycle the registered outputs are valid; pop whatever the driver predicted.
    always @(negedge clk) begin
        while (qA.size() > 0) chk("t1", obsA(), qA.pop_front());
        while (qB.size() > 0) chk("t4", obsB(), qB.pop_front());
    end

    task automatic cyc(input bit ld, input int lm, input int ls, input bit sa, input bit so, input bit cl);
        @(negedge clk);
        rst_n    = 1'b1;
        load     = ld;
        load_min = 8'(lm);
        load_sec = 6'(ls);
        start    = sa;
        stop     = so;
        clear    = cl;
        @(posedge clk);
        tick_models();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic async_rst();
        @(negedge clk);
        {load, start, stop, clear} = 4'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_t1", obsA(), '0);
        chk("arst_t4", obsB(), '0);
        @(posedge clk);
        tick_models();
    endtask

    initial begin
        rst_n = 1'b0;
        {load, start, stop, clear} = 4'b0;
        load_min = 8'd0;
        load_sec = 6'd0;
        async_rst();
        idle(2);
        // start with 0:00 is ignored
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);
        // 0:03 run to expiry, then start in EXPIRED
        cyc(1, 0, 3, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(6);
        cyc(0, 0, 0, 1, 0, 0);
        idle(3);
        // borrow from 2:00
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 2, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(130);
        cyc(0, 0, 0, 0, 0, 1);
        // pause/resume
        cyc(1, 0, 10, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(6);
        cyc(0, 0, 0, 0, 1, 0);
        idle(20);
        cyc(0, 0, 0, 1, 0, 0);
        idle(50);
        // clamp and priority
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 200, 63, 0, 0, 0);
        cyc(1, 1, 5, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(3);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(1, 7, 7, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);
        // load while running is ignored
        cyc(1, 0, 5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(1);
        cyc(1, 3, 0, 0, 0, 0);
        idle(3);
        // async reset mid-count
        cyc(1, 5, 20, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(3);
        async_rst();
        // auto-reload candidate
        cyc(1, 0, 2, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(20);
        // randomized control traffic
        for (int i = 0; i < 3000; i++) begin
            int lm;
            if (i == 1500) async_rst();
            lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 2));
            cyc($urandom_range(0, 19) == 0, lm, int'($urandom_range(0, 63)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
        end
        idle(2);
        @(negedge clk);
        #1;
        n_cmp++;
        if (qA.size() + qB.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", qA.size() + qB.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
